palette_lut_loader: RTL and testbench

Controller that loads a new 256-entry colour palette into the inactive half of a ping-pong palette LUT RAM and swaps banks at a frame boundary. Palette entries arrive on an AXI4-Stream slave and are written through a BRAM write port. The active bank index drives the upper LUT address bit of the palette lookup stage, so palette changes never tear mid-frame. It sits between the palette source (DMA/CPU stream) and the dual-port LUT RAM, whose read port is used by the pixel lookup path.

---
 rtl/palette_lut_loader.sv | 171 +++++++++++++++++
 tb/tb_palette_lut_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : palette_lut_loader
// Description : Loads a 256-entry colour palette from an AXI4-Stream slave
//               into the inactive half of a ping-pong palette LUT RAM. The
//               bank swap is deferred to the next frame boundary so the pixel
//               lookup path never sees a half-written palette.
// Ports       : axis_aclk / axis_areset   - clock, synchronous active-high reset
//               s_axis_*                  - palette entry stream (slave)
//               load_start                - request a new palette load
//               frame_start               - first pixel of a video frame
//               lut_bank_sel              - active bank for the lookup path
//               busy / swap_done / load_error - status
//               lut_ram_*                 - BRAM write port (byte addressed)
// Revision    : 1.0 - initial release
// ============================================================================
module palette_lut_loader #(
    parameter int COLOR_WIDTH = 16
) (
    input  logic        axis_aclk,
    input  logic        axis_areset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        load_start,
    input  logic        frame_start,
    output logic        lut_bank_sel,
    output logic        busy,
    output logic        swap_done,
    output logic        load_error,
    output logic        lut_ram_clk,
    output logic        lut_ram_rst,
    output logic        lut_ram_ena,
    output logic [3:0]  lut_ram_we,
    output logic [31:0] lut_ram_addr,
    output logic [31:0] lut_ram_wdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PENDING = 2'd3
    } state_t;

    localparam logic [7:0] c_last_index = 8'hFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_tready;
    logic [7:0]  r_index;
    logic        r_target_bank;
    logic        r_bank_sel;
    logic        r_swap_done;
    logic        r_load_error;
    logic        r_ram_ena;
    logic [31:0] r_ram_addr;
    logic [31:0] r_ram_wdata;

    logic        w_accept;
    logic        w_at_last;
    logic        w_load_go;
    logic        w_write;
    logic        w_frame_err;
    logic        w_swap;

    // Upper stream bits carry no palette information.
    if (COLOR_WIDTH < 32) begin : g_tdata_unused
        logic w_unused_tdata_hi;
        assign w_unused_tdata_hi = ^s_axis_tdata[31:COLOR_WIDTH];
    end

    // r_tready is only ever high in LOAD/DRAIN, so it doubles as the
    // "accepting" qualifier for the handshake.
    assign w_accept    = s_axis_tvalid & r_tready;
    assign w_at_last   = (r_index == c_last_index);
    assign w_load_go   = (r_state == ST_IDLE) & load_start;
    assign w_write     = (r_state == ST_LOAD) & w_accept;
    // Framing is wrong whenever tlast and "entry 255" disagree.
    assign w_frame_err = w_write & (w_at_last ^ s_axis_tlast);

    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (w_at_last) begin
                        w_state_nxt = s_axis_tlast ? ST_PENDING : ST_DRAIN;
                    end else if (s_axis_tlast) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_accept && s_axis_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PENDING: begin
                // The final RAM write is already committed by this edge, so a
                // frame_start on the first PENDING cycle may swap safely.
                if (frame_start) begin
                    w_state_nxt = ST_IDLE;
                    w_swap      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_state       <= ST_IDLE;
            r_tready      <= 1'b0;
            r_index       <= 8'd0;
            r_target_bank <= 1'b0;
            r_bank_sel    <= 1'b0;
            r_swap_done   <= 1'b0;
            r_load_error  <= 1'b0;
            r_ram_ena     <= 1'b0;
            r_ram_addr    <= 32'd0;
            r_ram_wdata   <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_tready    <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_DRAIN);
            r_swap_done <= w_swap;
            r_ram_ena   <= w_write;

            if (w_load_go) begin
                r_index       <= 8'd0;
                r_target_bank <= ~r_bank_sel;
                r_load_error  <= 1'b0;
            end else if (w_frame_err) begin
                r_load_error  <= 1'b1;
            end

            if (w_write) begin
                r_index     <= r_index + 8'd1;
                r_ram_addr  <= {21'd0, r_target_bank, r_index, 2'b00};
                r_ram_wdata <= 32'(s_axis_tdata[COLOR_WIDTH-1:0]);
            end

            if (w_swap) begin
                r_bank_sel <= r_target_bank;
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign lut_bank_sel  = r_bank_sel;
    assign busy          = (r_state != ST_IDLE);
    assign swap_done     = r_swap_done;
    assign load_error    = r_load_error;
    assign lut_ram_clk   = axis_aclk;
    assign lut_ram_rst   = 1'b0;
    assign lut_ram_ena   = r_ram_ena;
    assign lut_ram_we    = {4{r_ram_ena}};
    assign lut_ram_addr  = r_ram_addr;
    assign lut_ram_wdata = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_palette_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_palette_lut_loader
// Description : Self-checking bench for palette_lut_loader. A cycle-level
//               reference model (phase, beat index, banks, error flag) is
//               advanced from the stimulus and compared against the DUT on
//               every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_palette_lut_loader;

    logic        clk;
    logic        axis_areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        load_start;
    logic        frame_start;
    logic        lut_bank_sel;
    logic        busy;
    logic        swap_done;
    logic        load_error;
    logic        lut_ram_clk;
    logic        lut_ram_rst;
    logic        lut_ram_ena;
    logic [3:0]  lut_ram_we;
    logic [31:0] lut_ram_addr;
    logic [31:0] lut_ram_wdata;

    palette_lut_loader #(.COLOR_WIDTH(16)) dut (
        .axis_aclk     (clk),
        .axis_areset   (axis_areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .load_start    (load_start),
        .frame_start   (frame_start),
        .lut_bank_sel  (lut_bank_sel),
        .busy          (busy),
        .swap_done     (swap_done),
        .load_error    (load_error),
        .lut_ram_clk   (lut_ram_clk),
        .lut_ram_rst   (lut_ram_rst),
        .lut_ram_ena   (lut_ram_ena),
        .lut_ram_we    (lut_ram_we),
        .lut_ram_addr  (lut_ram_addr),
        .lut_ram_wdata (lut_ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;

    // Reference model. Phases: 0 idle, 1 loading, 2 draining, 3 awaiting frame.
    int          m_phase  = 0;
    int          m_idx    = 0;
    bit          m_bank   = 1'b0;
    bit          m_target = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_wr     = 1'b0;
    bit          m_swap   = 1'b0;
    bit          m_rstchk = 1'b0;
    bit          m_acc    = 1'b0;
    logic [31:0] m_addr   = 32'd0;
    logic [31:0] m_data   = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare DUT against the model, then advance the model with
    // the inputs that the coming rising edge will sample.
    task automatic tick();
        @(negedge clk);
        chk("tready",     {31'd0, s_axis_tready}, {31'd0, (m_phase == 1 || m_phase == 2)});
        chk("busy",       {31'd0, busy},          {31'd0, (m_phase != 0)});
        chk("bank_sel",   {31'd0, lut_bank_sel},  {31'd0, m_bank});
        chk("swap_done",  {31'd0, swap_done},     {31'd0, m_swap});
        chk("load_error", {31'd0, load_error},    {31'd0, m_err});
        chk("ram_ena",    {31'd0, lut_ram_ena},   {31'd0, m_wr});
        chk("ram_we",     {28'd0, lut_ram_we},    m_wr ? 32'hF : 32'h0);
        chk("ram_rst",    {31'd0, lut_ram_rst},   32'd0);
        chk("ram_clk",    {31'd0, lut_ram_clk},   {31'd0, clk});
        if (m_wr) begin
            chk("ram_addr",  lut_ram_addr,  m_addr);
            chk("ram_wdata", lut_ram_wdata, m_data);
        end
        if (m_rstchk) begin
            chk("rst_addr",  lut_ram_addr,  32'd0);
            chk("rst_wdata", lut_ram_wdata, 32'd0);
        end
        if (lut_ram_ena === 1'b1) n_wr++;

        m_wr     = 1'b0;
        m_swap   = 1'b0;
        m_rstchk = 1'b0;
        m_acc    = s_axis_tvalid && (m_phase == 1 || m_phase == 2);
        if (axis_areset) begin
            m_phase  = 0;
            m_idx    = 0;
            m_bank   = 1'b0;
            m_target = 1'b0;
            m_err    = 1'b0;
            m_acc    = 1'b0;
            m_rstchk = 1'b1;
        end else begin
            case (m_phase)
                0: if (load_start) begin
                    m_phase  = 1;
                    m_idx    = 0;
                    m_target = !m_bank;
                    m_err    = 1'b0;
                end
                1: if (m_acc) begin
                    m_wr   = 1'b1;
                    m_addr = 32'h400 * m_target + 4 * m_idx;
                    m_data = s_axis_tdata & 32'h0000_FFFF;
                    if (m_idx == 255) begin
                        m_phase = s_axis_tlast ? 3 : 2;
                        if (!s_axis_tlast) m_err = 1'b1;
                    end else if (s_axis_tlast) begin
                        m_phase = 0;
                        m_err   = 1'b1;
                    end
                    m_idx++;
                end
                2: if (m_acc && s_axis_tlast) m_phase = 0;
                default: if (frame_start) begin
                    m_bank  = m_target;
                    m_swap  = 1'b1;
                    m_phase = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Streams n beats (tlast on beat last_idx) with the given tvalid duty in
    // percent. noise adds stray load_start/frame_start pulses; rst_at >= 0
    // asserts reset when that beat number is reached.
    task automatic send(input int n, input int last_idx, input int duty,
                        input bit rnd_data, input bit noise, input int rst_at);
        int  beat = 0;
        int  cyc  = 0;
        bit  done = 1'b0;
        while (beat < n && !done) begin
            if (cyc > n * 8 + 64) begin
                n_tests++;
                n_fail++;
                $error("FAIL beat_timeout observed=%0d beats expected=%0d", beat, n);
                done = 1'b1;
            end else if (rst_at >= 0 && beat == rst_at) begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                load_start    = 1'b0;
                frame_start   = 1'b0;
                axis_areset   = 1'b1;
                tick();
                axis_areset   = 1'b0;
                done = 1'b1;
            end else begin
                s_axis_tvalid = (duty >= 100) || ($urandom_range(99) < duty);
                s_axis_tdata  = rnd_data ? $urandom : beat;
                s_axis_tlast  = (beat == last_idx);
                load_start    = noise && ($urandom_range(15) == 0);
                frame_start   = noise && ($urandom_range(15) == 0);
                tick();
                if (m_acc) beat++;
                cyc++;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        load_start    = 1'b0;
        frame_start   = 1'b0;
    endtask

    initial begin
        axis_areset   = 1'b1;
        s_axis_tdata  = 32'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        load_start    = 1'b0;
        frame_start   = 1'b0;
        @(posedge clk);
        #1;
        tick();
        axis_areset = 1'b0;
        idle(2);

        // Full load, data = index, into bank 1; swap on a later frame.
        n_wr = 0;
        pulse_load();
        send(256, 255, 100, 1'b0, 1'b0, -1);
        idle(4);
        chk("load1_writes", n_wr, 256);
        chk("load1_bank_held", {31'd0, lut_bank_sel}, 32'd0);
        pulse_frame();
        idle(2);
        chk("load1_bank_after", {31'd0, lut_bank_sel}, 32'd1);

        // Second load into bank 0, frame_start on the very first PENDING cycle.
        n_wr = 0;
        pulse_load();
        send(256, 255, 100, 1'b1, 1'b0, -1);
        pulse_frame();
        idle(2);
        chk("load2_writes", n_wr, 256);
        chk("load2_bank_after", {31'd0, lut_bank_sel}, 32'd0);

        // Early tlast on beat 99.
        n_wr = 0;
        pulse_load();
        send(100, 99, 100, 1'b1, 1'b0, -1);
        idle(2);
        chk("short_writes", n_wr, 100);
        chk("short_error", {31'd0, load_error}, 32'd1);
        pulse_frame();
        idle(2);
        chk("short_bank", {31'd0, lut_bank_sel}, 32'd0);

        // Overlong packet: 256 writes then 44 drained beats.
        n_wr = 0;
        pulse_load();
        send(300, 299, 100, 1'b1, 1'b0, -1);
        idle(2);
        chk("long_writes", n_wr, 256);
        chk("long_error", {31'd0, load_error}, 32'd1);
        chk("long_idle", {31'd0, busy}, 32'd0);
        pulse_frame();
        idle(1);

        // New load clears the error; ~50% tvalid with stray control pulses.
        n_wr = 0;
        pulse_load();
        chk("error_cleared", {31'd0, load_error}, 32'd0);
        send(256, 255, 50, 1'b1, 1'b1, -1);
        idle(3);
        chk("gap_writes", n_wr, 256);
        chk("gap_bank_held", {31'd0, lut_bank_sel}, 32'd0);
        pulse_frame();
        idle(2);
        chk("gap_bank_after", {31'd0, lut_bank_sel}, 32'd1);

        // load_start together with frame_start in IDLE, then reset mid-load.
        load_start  = 1'b1;
        frame_start = 1'b1;
        tick();
        load_start  = 1'b0;
        frame_start = 1'b0;
        chk("same_cycle_bank", {31'd0, lut_bank_sel}, 32'd1);
        send(256, 255, 100, 1'b1, 1'b0, 128);
        idle(1);
        chk("reset_bank", {31'd0, lut_bank_sel}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // After reset the next full load targets bank 1.
        n_wr = 0;
        pulse_load();
        send(256, 255, 100, 1'b1, 1'b0, -1);
        pulse_frame();
        idle(2);
        chk("post_reset_writes", n_wr, 256);
        chk("post_reset_bank", {31'd0, lut_bank_sel}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
